// File: rtl/cache_controller_pkg.sv
// Shared definitions for the MEM-stage cache controller and the word cache it sequences:
// state encodings, data-memory base address and word-address width.
package cache_controller_pkg;

  localparam int unsigned CC_ADDR_BASE = 1024;
  localparam int unsigned CC_ADDR_W    = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_FILL    = 2'd2,
    ST_WRITE   = 2'd3
  } cc_state_e;

endpackage

// File: rtl/cache_controller.sv
// MEM-stage cache controller: 0-cycle read hits, read-miss fetch and fill,
// write-through no-allocate stores that invalidate any matching cache line.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE = CC_ADDR_BASE,
  parameter int unsigned ADDR_W    = CC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              cache_rd_en,
  output logic              cache_wr_en,
  output logic              cache_inv_en,
  output logic [ADDR_W-1:0] cache_address,
  output logic [31:0]       cache_data_in,
  input  logic              cache_hit,
  input  logic [31:0]       cache_data_out,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ready
);

  cc_state_e   state_q, state_d;
  logic [31:0] fill_q, fill_d;

  logic [31:0]       byte_offset;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_bits;

  // Out-of-range addresses simply wrap; the byte-lane and high bits are dropped.
  assign byte_offset      = address - 32'(ADDR_BASE);
  assign word_addr        = byte_offset[ADDR_W+1:2];
  assign unused_addr_bits = ^{byte_offset[31:ADDR_W+2], byte_offset[1:0]};

  assign cache_address = word_addr;
  assign sram_address  = word_addr;
  assign cache_data_in = fill_q;
  assign sram_wdata    = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    ready        = 1'b0;
    rdata        = fill_q;
    cache_rd_en  = 1'b0;
    cache_wr_en  = 1'b0;
    cache_inv_en = 1'b0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;

    unique case (state_q)
      // A store wins over a simultaneous load, so no lookup is issued then.
      ST_IDLE: begin
        if (mem_w_en) begin
          cache_inv_en = 1'b1;
          state_d      = ST_WRITE;
        end else if (mem_r_en) begin
          cache_rd_en = 1'b1;
          if (cache_hit) begin
            ready = 1'b1;
            rdata = cache_data_out;
          end else begin
            state_d = ST_RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end

      ST_RD_MISS: begin
        sram_rd_en = 1'b1;
        if (sram_ready) begin
          fill_d  = sram_rdata;
          state_d = ST_FILL;
        end
      end

      ST_FILL: begin
        cache_wr_en = 1'b1;
        ready       = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_WRITE: begin
        sram_wr_en = 1'b1;
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller with a cache/SRAM stub and a
// transaction-level reference model of memory contents, cached words and stall lengths.
module tb_cache_controller;
  import cache_controller_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        cache_rd_en;
  logic        cache_wr_en;
  logic        cache_inv_en;
  logic [17:0] cache_address;
  logic [31:0] cache_data_in;
  logic        cache_hit;
  logic [31:0] cache_data_out;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [17:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  int compared;
  int mismatched;

  cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .mem_r_en       (mem_r_en),
    .mem_w_en       (mem_w_en),
    .address        (address),
    .wdata          (wdata),
    .rdata          (rdata),
    .ready          (ready),
    .cache_rd_en    (cache_rd_en),
    .cache_wr_en    (cache_wr_en),
    .cache_inv_en   (cache_inv_en),
    .cache_address  (cache_address),
    .cache_data_in  (cache_data_in),
    .cache_hit      (cache_hit),
    .cache_data_out (cache_data_out),
    .sram_rd_en     (sram_rd_en),
    .sram_wr_en     (sram_wr_en),
    .sram_address   (sram_address),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .sram_ready     (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background SRAM contents; word 1 (byte 0x404) holds 0xDEADBEEF.
  function automatic logic [31:0] bg_word(input int w);
    return 32'hDEADBEEF ^ (32'(w - 1) * 32'h9E3779B1);
  endfunction

  function automatic int ref_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off / 32'd4) % 32'd262144);
  endfunction

  // Cache and SRAM stubs: a never-evicting cache and an SRAM with programmable latency.
  bit        cache_valid  [0:262143];
  bit [31:0] cache_mem    [0:262143];
  bit        sram_written [0:262143];
  bit [31:0] sram_mem     [0:262143];
  int        sram_lat;
  int        sram_cnt;
  logic      force_ready;

  assign cache_hit      = cache_valid[cache_address];
  assign cache_data_out = cache_mem[cache_address];
  assign sram_rdata     = sram_written[sram_address] ? sram_mem[sram_address] : bg_word(int'(sram_address));
  assign sram_ready     = force_ready | ((sram_rd_en | sram_wr_en) && (sram_cnt == sram_lat - 1));

  always @(posedge clk or posedge rst) begin
    if (rst) sram_cnt <= 0;
    else if ((sram_rd_en || sram_wr_en) && !sram_ready) sram_cnt <= sram_cnt + 1;
    else sram_cnt <= 0;
  end

  always @(posedge clk) begin
    if (cache_wr_en) begin
      cache_valid[cache_address] <= 1'b1;
      cache_mem[cache_address]   <= cache_data_in;
    end
    if (cache_inv_en) cache_valid[cache_address] <= 1'b0;
    if (sram_wr_en && sram_ready) begin
      sram_written[sram_address] <= 1'b1;
      sram_mem[sram_address]     <= sram_wdata;
    end
  end

  // Reference model: what memory holds and which words the cache should hold.
  bit [31:0] ref_mem    [int];
  bit        ref_cached [int];

  function automatic logic [31:0] ref_read(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : bg_word(w);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    mem_r_en = r;
    mem_w_en = w;
    address  = a;
    wdata    = d;
  endtask

  // Called at posedge+1; returns at posedge+1 after the ready cycle, request released.
  task automatic doLoad(input logic [31:0] a, input int lat, input bit drop);
    int          w;
    bit          hit;
    int          low;
    bit          done;
    bit          saw_sram;
    bit          saw_fill;
    logic [31:0] got;
    w        = ref_word(a);
    hit      = ref_cached.exists(w);
    sram_lat = lat;
    low      = 0;
    done     = 0;
    saw_sram = 0;
    saw_fill = 0;
    got      = '0;
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("rd_cache_addr", 32'(cache_address), 32'(w));
        checkOutput("rd_sram_addr", 32'(sram_address), 32'(w));
        checkOutput("rd_lookup", 32'(cache_rd_en), 32'd1);
      end
      if (sram_rd_en) saw_sram = 1;
      if (cache_wr_en) saw_fill = 1;
      if (ready) begin
        done = 1;
        got  = rdata;
      end else begin
        low++;
      end
      if (drop && c == 1) mem_r_en = 1'b0;
    end
    checkOutput("rd_done", 32'(done), 32'd1);
    checkOutput("rd_stall", 32'(low), hit ? 32'd0 : 32'(lat + 1));
    checkOutput("rd_data", got, ref_read(w));
    checkOutput("rd_sram_used", 32'(saw_sram), hit ? 32'd0 : 32'd1);
    checkOutput("rd_fill", 32'(saw_fill), hit ? 32'd0 : 32'd1);
    ref_cached[w] = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d, input int lat, input bit both, input bit drop);
    int w;
    int low;
    int inv_cnt;
    int fill_cnt;
    int lookup_cnt;
    bit done;
    bit saw_sram;
    w          = ref_word(a);
    sram_lat   = lat;
    low        = 0;
    inv_cnt    = 0;
    fill_cnt   = 0;
    lookup_cnt = 0;
    done       = 0;
    saw_sram   = 0;
    applyStimulus(both, 1'b1, a, d);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("wr_cache_addr", 32'(cache_address), 32'(w));
      if (cache_inv_en) inv_cnt++;
      if (cache_wr_en) fill_cnt++;
      if (cache_rd_en) lookup_cnt++;
      if (sram_wr_en) saw_sram = 1;
      if (sram_wr_en && c > 0) checkOutput("wr_sram_data", sram_wdata, d);
      if (ready) done = 1;
      else low++;
      if (drop && c == 1) begin
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
      end
    end
    checkOutput("wr_done", 32'(done), 32'd1);
    checkOutput("wr_stall", 32'(low), 32'(lat));
    checkOutput("wr_inv_once", 32'(inv_cnt), 32'd1);
    checkOutput("wr_no_fill", 32'(fill_cnt), 32'd0);
    checkOutput("wr_no_lookup", 32'(lookup_cnt), 32'd0);
    checkOutput("wr_sram_used", 32'(saw_sram), 32'd1);
    ref_mem[w] = d;
    if (ref_cached.exists(w)) ref_cached.delete(w);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    compared    = 0;
    mismatched  = 0;
    sram_lat    = 1;
    force_ready = 1'b0;
    rst         = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h400, 32'h0);

    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_strobes", 32'({cache_rd_en, cache_wr_en, cache_inv_en, sram_rd_en, sram_wr_en}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed: miss, hit, write-invalidate");
    doLoad(32'h404, 3, 0);
    doLoad(32'h404, 3, 0);
    doStore(32'h404, 32'h12345678, 2, 0, 0);
    doLoad(32'h404, 2, 0);

    $display("[TB] directed: simultaneous request, stall timing, wrap");
    doStore(32'h408, 32'hA5A5_0408, 3, 1, 0);
    doLoad(32'h408, 2, 0);
    doStore(32'h40C, 32'h0BAD_F00D, 5, 0, 0);
    doLoad(32'h410, 5, 0);
    doLoad(32'h400, 1, 0);
    doLoad(32'h400 + 32'hFFFFC, 1, 0);

    $display("[TB] directed: dropped requests, stray sram_ready");
    doLoad(32'h414, 4, 1);
    doLoad(32'h414, 4, 0);
    doStore(32'h418, 32'hCAFE_0418, 4, 0, 1);
    doLoad(32'h418, 2, 0);
    @(negedge clk);
    force_ready = 1'b1;
    #1;
    checkOutput("idle_stray_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 force_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_stray", 32'({ready, sram_rd_en, sram_wr_en, cache_wr_en}), 32'b1000);
    @(posedge clk);
    #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 32'h3FC : 32'h400 + 32'hFFFFC;
      else a = 32'h400 + 32'(4 * $urandom_range(0, 11));
      d = $urandom;
      if (op < 6) doLoad(a, int'($urandom_range(1, 6)), 0);
      else doStore(a, d, int'($urandom_range(1, 6)), op == 9, 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] reset during read miss");
    sram_lat = 20;
    applyStimulus(1'b1, 1'b0, 32'h800, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(sram_rd_en), 32'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h800, 32'h0);
    #1;
    checkOutput("rst_sram_rd_en", 32'(sram_rd_en), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_cache_wr_en", 32'(cache_wr_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    doLoad(32'h800, 2, 0);
    doLoad(32'h800, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
